// File: rtl/aes_pipe_pkg.sv
// Shared AES pipeline constants: block width, pipeline latency, tag width and FIPS-197 vectors.
package aes_pipe_pkg;

    localparam int AES_BLOCK_W      = 128;
    localparam int AES_PIPE_LATENCY = 12;
    localparam int AES_TAG_W        = 4;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_TAG_W-1:0]   aes_tag_t;

    // FIPS-197 Appendix C.1 known-answer vector for AES-128.
    localparam aes_block_t FIPS197_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_block_t FIPS197_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam aes_block_t FIPS197_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_result_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head and a sticky overflow flag.
module aes_result_fifo #(
    parameter int DATA_W = 132,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop_req,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       rd_next;
    logic [AW:0]       occ;
    logic              empty;
    logic              full;
    logic              pop;
    logic              wr_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rvalid  = !empty;
    assign pop     = pop_req && !empty;
    // A pop frees its slot before the write lands, so push is legal when full and popping.
    assign wr_en   = push && (!full || pop);
    assign occ     = wr_ptr - rd_ptr;
    assign rd_next = rd_ptr + PTR_ONE;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rdata    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end
            // Head register: follows the next entry, or the incoming word when it becomes head.
            if (pop) begin
                if (occ == PTR_ONE) begin
                    if (wr_en) begin
                        rdata <= wdata;
                    end
                end else begin
                    rdata <= mem[rd_next[AW-1:0]];
                end
            end else if (empty && wr_en) begin
                rdata <= wdata;
            end
        end
    end

endmodule

// File: rtl/aes_result_collector.sv
// Tracks valid beats through the AES pipeline, captures ciphertext into a credit-guarded FIFO.
// Optional AES_COLLECT_STATS_EN adds blk_count and inflight outputs.
module aes_result_collector
    import aes_pipe_pkg::*;
#(
    parameter int LATENCY = AES_PIPE_LATENCY,
    parameter int DEPTH   = 16,
    parameter int TAG_W   = AES_TAG_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic [AES_BLOCK_W-1:0] ct_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   err_overflow
`ifdef AES_COLLECT_STATS_EN
    ,
    output logic [31:0]            blk_count,
    output logic [$clog2(DEPTH):0] inflight
`endif
);

    localparam int CW = $clog2(DEPTH);
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);
    localparam logic [CW:0] CREDIT_ONE = (CW+1)'(1);

    // Handshakes: a beat transfers on a rising edge where valid & ready are both high;
    // valid never waits on ready, and ready depends only on registered state.
    logic              acc;
    logic              pop;
    logic              run_q;
    logic [CW:0]       credits;
    logic [LATENCY-1:0] dl_valid;
    logic [TAG_W-1:0]  dl_tag [LATENCY];
    logic              capture;

    assign in_ready = run_q && (credits != '0);
    assign acc      = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign capture  = dl_valid[LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dl_valid <= '0;
            credits  <= CREDIT_MAX;
            run_q    <= 1'b0;
        end else begin
            dl_valid <= {dl_valid[LATENCY-2:0], acc};
            run_q    <= 1'b1;
            case ({acc, pop})
                2'b10:   credits <= credits - CREDIT_ONE;
                2'b01:   credits <= credits + CREDIT_ONE;
                default: credits <= credits;
            endcase
        end
    end

    // Tags ride alongside the valid bits; a stage's tag is meaningless when its valid is 0.
    always_ff @(posedge clk) begin
        dl_tag[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            dl_tag[i] <= dl_tag[i-1];
        end
    end

    aes_result_fifo #(
        .DATA_W (AES_BLOCK_W + TAG_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (capture),
        .wdata    ({ct_in, dl_tag[LATENCY-1]}),
        .pop_req  (out_ready),
        .rvalid   (out_valid),
        .rdata    ({out_data, out_tag}),
        .overflow (err_overflow)
    );

`ifdef AES_COLLECT_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_count <= '0;
        end else if (pop) begin
            blk_count <= blk_count + 32'd1;
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + (CW+1)'(dl_valid[i]);
        end
    end
`endif

endmodule

// File: tb/tb_aes_result_collector.sv
// Directed bench for aes_result_collector; stats checks compile in with AES_COLLECT_STATS_EN.
`timescale 1ns/1ps
module tb_aes_result_collector;
    import aes_pipe_pkg::*;

    localparam int LAT   = 12;
    localparam int DEPTH = 16;
    localparam int TAG_W = 4;
    localparam int EW    = AES_BLOCK_W + TAG_W;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [TAG_W-1:0]       in_tag = '0;
    logic [AES_BLOCK_W-1:0] ct_in = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [AES_BLOCK_W-1:0] out_data;
    logic [TAG_W-1:0]       out_tag;
    logic                   err_overflow;
`ifdef AES_COLLECT_STATS_EN
    logic [31:0]            blk_count;
    logic [4:0]             inflight;
`endif

    always #5 clk = ~clk;

    aes_result_collector #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_tag       (in_tag),
        .ct_in        (ct_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .err_overflow (err_overflow)
`ifdef AES_COLLECT_STATS_EN
        ,
        .blk_count    (blk_count),
        .inflight     (inflight)
`endif
    );

    int cyc = 0;
    int pass_cnt = 0;
    int total_cnt = 0;
    int fips_edge = -1;
    int n_acc = 0;
    int n_pop = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic             iv;
        logic [TAG_W-1:0] tag;
        logic             ordy;
        logic             exp_ir;
        logic             exp_ov;
        logic [TAG_W-1:0] exp_tag;
    } vec_t;
    vec_t tbl[18];

    // Ciphertext the bench places on ct_in for the edge with index n.
    function automatic logic [AES_BLOCK_W-1:0] ct_of(int n);
        logic [31:0] w;
        w = 32'(n);
        if (n == fips_edge) return FIPS197_CT;
        return {w ^ 32'hA5A5_0F0F, ~w, {w[15:0], w[31:16]}, w + 32'h1357_9BDF};
    endfunction

    task automatic check(string name, logic [EW-1:0] act, logic [EW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Book-keep the handshakes that will occur on the coming edge, then advance one cycle.
    task automatic tick();
        logic [EW-1:0] e;
        if (in_valid && in_ready) begin
            exp_q.push_back({ct_of(cyc + LAT), in_tag});
            n_acc++;
        end
        if (out_valid && out_ready) begin
            n_pop++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL pop_unexpected: got %h expected no entry", {out_data, out_tag});
            end else begin
                e = exp_q.pop_front();
                check("pop_data", {out_data, out_tag}, e);
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        ct_in = ct_of(cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        int bad;
        ct_in = ct_of(0);

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_err_overflow", err_overflow, 0);
        reset = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // FIPS-197 beat
        fips_edge = cyc + LAT;
        in_valid = 1'b1; in_tag = 4'd3; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        bad = 0;
        repeat (LAT - 1) begin
            tick();
            if (out_valid) bad++;
        end
        check("fips_early_valid", 32'(bad), 0);
        tick();
        check("fips_out_valid", out_valid, 1);
        check("fips_out_data", out_data, FIPS197_CT);
        check("fips_out_tag", out_tag, 4'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fips_after_pop_valid", out_valid, 0);
        check("fips_hold_data", out_data, FIPS197_CT);
        fips_edge = -1;

        // Bubbles: accepts 1,0,1,1,0 land on rows 12, 14, 15
        for (int i = 0; i < 18; i++) tbl[i] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[0]  = '{1'b1, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 4'h5, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[2]  = '{1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[3]  = '{1'b1, 4'hC, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[4]  = '{1'b0, 4'h6, 1'b1, 1'b1, 1'b0, 4'h0};
        tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hA};
        tbl[14] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hB};
        tbl[15] = '{1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hC};
        for (int i = 0; i < 18; i++) begin
            in_valid = tbl[i].iv; in_tag = tbl[i].tag; out_ready = tbl[i].ordy;
            tick();
            check($sformatf("bub_in_ready_%0d", i), in_ready, tbl[i].exp_ir);
            check($sformatf("bub_out_valid_%0d", i), out_valid, tbl[i].exp_ov);
            if (tbl[i].exp_ov) check($sformatf("bub_out_tag_%0d", i), out_tag, tbl[i].exp_tag);
        end
        in_valid = 1'b0;
        check("bub_drained", 32'(exp_q.size()), 0);

        // Back-pressure fill
        out_ready = 1'b0; in_valid = 1'b1;
        start = n_acc;
        for (int i = 0; i < 16; i++) begin in_tag = 4'(n_acc - start); tick(); end
        check("fill_back_to_back", 32'(n_acc - start), 16);
        for (int i = 0; i < 24; i++) begin in_tag = 4'(n_acc - start); tick(); end
        check("fill_total", 32'(n_acc - start), 16);
        check("fill_in_ready", in_ready, 0);
        check("fill_out_valid", out_valid, 1);
        check("fill_head_tag", out_tag, 4'd0);
        check("fill_no_overflow", err_overflow, 0);

        // Credit return from full
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("credit_return_ready", in_ready, 1);
        in_valid = 1'b1; in_tag = 4'hE;
        tick();
        in_valid = 1'b0;
        check("credit_consumed", in_ready, 0);
        repeat (LAT) tick();
        check("refill_no_overflow", err_overflow, 0);
        out_ready = 1'b1;
        repeat (20) tick();
        check("refill_drained_q", 32'(exp_q.size()), 0);
        check("refill_drained_valid", out_valid, 0);

        // Reset mid-flight: 3 in the FIFO, 5 in the delay line
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin in_tag = 4'(i); tick(); end
        in_valid = 1'b0;
        repeat (LAT) tick();
        in_valid = 1'b1;
        for (int i = 4; i <= 8; i++) begin in_tag = 4'(i); tick(); end
        in_valid = 1'b0;
        tick(); tick();
        check("mid_fifo_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_overflow", err_overflow, 0);
        check("mid_rst_in_ready", in_ready, 0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        tick();
        check("mid_release_ready", in_ready, 1);
        out_ready = 1'b1;
        bad = 0;
        repeat (2 * LAT) begin
            tick();
            if (out_valid) bad++;
        end
        check("mid_no_stale", 32'(bad), 0);
        out_ready = 1'b0; in_valid = 1'b1;
        start = n_acc;
        repeat (20) begin in_tag = 4'(n_acc - start); tick(); end
        in_valid = 1'b0;
        check("mid_credits_16", 32'(n_acc - start), 16);
        out_ready = 1'b1;
        repeat (LAT + 20) tick();
        check("mid_drained", 32'(exp_q.size()), 0);

`ifdef AES_COLLECT_STATS_EN
        begin
            logic [LAT-1:0] hist;
            logic acc_now;
            int pop_base;
            int budget;
            reset = 1'b0;
            #1;
            exp_q.delete();
            tick();
            reset = 1'b1;
            tick();
            check("stats_rst_count", blk_count, 0);
            hist = '0; bad = 0; budget = 0;
            start = n_acc; pop_base = n_pop;
            out_ready = 1'b1;
            while ((n_pop - pop_base) < 1000 && budget < 1200) begin
                in_valid = ((n_acc - start) < 1000);
                in_tag = 4'(n_acc);
                acc_now = in_valid && in_ready;
                tick();
                hist = {hist[LAT-2:0], acc_now};
                if (32'(inflight) != 32'($countones(hist))) bad++;
                budget++;
            end
            in_valid = 1'b0;
            tick();
            check("stats_blk_count", blk_count, 1000);
            check("stats_inflight", 32'(bad), 0);
            check("stats_throughput", 32'(budget <= 1000 + LAT + 2), 1);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
